// File: rtl/cache_refill_ctrl_if.sv
// Cache-side miss signals and 32-bit memory port of the refill controller.
// The controller connects through the master modport; the cache/memory side uses slave.
interface cache_refill_ctrl_if #(
    parameter int ADR_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
);
    localparam int LINE_W = WORDS_PER_LINE * DATA_WIDTH;

    logic                  miss_req_i;
    logic [ADR_WIDTH-1:0]  miss_adr_i;
    logic                  victim_dirty_i;
    logic [ADR_WIDTH-1:0]  victim_adr_i;
    logic [LINE_W-1:0]     victim_dat_i;
    logic                  busy_o;
    logic                  refill_valid_o;
    logic [LINE_W-1:0]     refill_dat_o;
    logic                  mem_req_o;
    logic [ADR_WIDTH-1:0]  mem_adr_o;
    logic [DATA_WIDTH-1:0] mem_dat_o;
    logic                  mem_rdwr_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_dat_i;

    modport master (
        input  miss_req_i, miss_adr_i, victim_dirty_i, victim_adr_i, victim_dat_i,
        input  mem_ack_i, mem_dat_i,
        output busy_o, refill_valid_o, refill_dat_o,
        output mem_req_o, mem_adr_o, mem_dat_o, mem_rdwr_o
    );

    modport slave (
        output miss_req_i, miss_adr_i, victim_dirty_i, victim_adr_i, victim_dat_i,
        output mem_ack_i, mem_dat_i,
        input  busy_o, refill_valid_o, refill_dat_o,
        input  mem_req_o, mem_adr_o, mem_dat_o, mem_rdwr_o
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss sequencer: optional dirty-victim write-back, then in-order line fetch,
// delivered to the cache as one full-line refill pulse.
module cache_refill_ctrl #(
    parameter int ADR_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                clk,
    input  logic                rst,
    cache_refill_ctrl_if.master bus
);
    localparam int LINE_W = WORDS_PER_LINE * DATA_WIDTH;
    localparam int OFS    = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);
    localparam int CNT_W  = $clog2(WORDS_PER_LINE);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int TAG_W  = ADR_WIDTH - OFS;

    typedef enum logic [1:0] {IDLE, WB, RF, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TAG_W-1:0]   miss_line_q, miss_line_d;
    logic [TAG_W-1:0]   victim_line_q, victim_line_d;
    logic [LINE_W-1:0]  victim_dat_q, victim_dat_d;
    logic [LINE_W-1:0]  refill_dat_q, refill_dat_d;
    logic               last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            miss_line_q   <= '0;
            victim_line_q <= '0;
            victim_dat_q  <= '0;
            refill_dat_q  <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            miss_line_q   <= miss_line_d;
            victim_line_q <= victim_line_d;
            victim_dat_q  <= victim_dat_d;
            refill_dat_q  <= refill_dat_d;
        end
    end

    // Beats advance only on ack; the counter wraps to 0 after the last beat of each phase.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        miss_line_d   = miss_line_q;
        victim_line_d = victim_line_q;
        victim_dat_d  = victim_dat_q;
        refill_dat_d  = refill_dat_q;
        last_beat     = (beat_cnt_q == CNT_W'(WORDS_PER_LINE - 1));
        case (state_q)
            IDLE: begin
                if (bus.miss_req_i) begin
                    miss_line_d   = bus.miss_adr_i[ADR_WIDTH-1:OFS];
                    victim_line_d = bus.victim_adr_i[ADR_WIDTH-1:OFS];
                    victim_dat_d  = bus.victim_dat_i;
                    beat_cnt_d    = '0;
                    state_d       = bus.victim_dirty_i ? WB : RF;
                end
            end
            WB: begin
                if (bus.mem_ack_i) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = RF;
                    end
                end
            end
            RF: begin
                if (bus.mem_ack_i) begin
                    refill_dat_d[int'(beat_cnt_q) * DATA_WIDTH +: DATA_WIDTH] = bus.mem_dat_i;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o         = (state_q != IDLE);
        bus.refill_valid_o = 1'b0;
        bus.refill_dat_o   = refill_dat_q;
        bus.mem_req_o      = 1'b0;
        bus.mem_adr_o      = '0;
        bus.mem_dat_o      = '0;
        bus.mem_rdwr_o     = 1'b0;
        case (state_q)
            WB: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_rdwr_o = 1'b1;
                bus.mem_adr_o  = {victim_line_q, beat_cnt_q, {BYTE_W{1'b0}}};
                bus.mem_dat_o  = victim_dat_q[int'(beat_cnt_q) * DATA_WIDTH +: DATA_WIDTH];
            end
            RF: begin
                bus.mem_req_o = 1'b1;
                bus.mem_adr_o = {miss_line_q, beat_cnt_q, {BYTE_W{1'b0}}};
            end
            DONE:    bus.refill_valid_o = 1'b1;
            default: ;
        endcase
    end
endmodule
